computer_system_multi_timer: RTL and testbench



---
 rtl/computer_system_multi_timer_pkg.sv | 15 +
 rtl/computer_system_timer_channel.sv | 72 +++++++
 rtl/computer_system_multi_timer.sv | 50 +++++
 tb/tb_computer_system_multi_timer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/computer_system_multi_timer_pkg.sv
// computer_system_multi_timer_pkg: register map and bit positions shared by the timer files
package computer_system_multi_timer_pkg;
    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;
    localparam int STAT_TO    = 0;
    localparam int STAT_RUN   = 1;
endpackage

// File: rtl/computer_system_timer_channel.sv
// computer_system_timer_channel: one down-counter with period, snapshot, run/timeout state and read mux
module computer_system_timer_channel
    import computer_system_multi_timer_pkg::*;
#(
    parameter int          CNT_W          = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h00BEBC1F,
    parameter bit          RUN_AT_RESET   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [2:0]  reg_sel,
    input  logic [15:0] writedata,
    output logic [15:0] rdata,
    output logic        irq
);
    logic [CNT_W-1:0] cnt, period, snap;
    logic [31:0] period_x, snap_x;
    logic [15:0] stat, ctrl;
    logic run, to, ito, cont, reload;
    logic wr_stat, wr_ctrl, wr_pl, wr_ph, wr_snap, tmo, start, stop;
    assign wr_stat  = wr && reg_sel == REG_STATUS;
    assign wr_ctrl  = wr && reg_sel == REG_CONTROL;
    assign wr_pl    = wr && reg_sel == REG_PERIOD_L;
    assign wr_ph    = wr && reg_sel == REG_PERIOD_H;
    assign wr_snap  = wr && (reg_sel == REG_SNAP_L || reg_sel == REG_SNAP_H);
    assign start    = wr_ctrl && writedata[CTRL_START];
    assign stop     = wr_ctrl && writedata[CTRL_STOP];
    assign tmo      = run && cnt == '0;
    assign period_x = 32'(period);
    assign snap_x   = 32'(snap);
    assign irq      = to & ito;
    always_comb begin
        stat = '0;
        stat[STAT_TO] = to;
        stat[STAT_RUN] = run;
        ctrl = '0;
        ctrl[CTRL_ITO] = ito;
        ctrl[CTRL_CONT] = cont;
    end
    always_comb
        rdata = reg_sel == REG_STATUS   ? stat :
                reg_sel == REG_CONTROL  ? ctrl :
                reg_sel == REG_PERIOD_L ? period_x[15:0] :
                reg_sel == REG_PERIOD_H ? period_x[31:16] :
                reg_sel == REG_SNAP_L   ? snap_x[15:0] :
                reg_sel == REG_SNAP_H   ? snap_x[31:16] : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= DEFAULT_PERIOD[CNT_W-1:0];
            period <= DEFAULT_PERIOD[CNT_W-1:0];
            snap   <= '0;
            run    <= RUN_AT_RESET;
            to     <= 1'b0;
            ito    <= 1'b0;
            cont   <= 1'b1;
            reload <= 1'b0;
        end else begin
            cnt    <= (reload || tmo) ? period : run ? cnt - CNT_W'(1) : cnt;
            reload <= wr_pl || wr_ph;
            to     <= tmo || (to && !wr_stat);
            run    <= stop ? 1'b0 : (tmo && !cont) ? 1'b0 : start ? 1'b1 : run;
            if (wr_ctrl) begin
                ito  <= writedata[CTRL_ITO];
                cont <= writedata[CTRL_CONT];
            end
            if (wr_pl) period[15:0] <= writedata;
            if (wr_ph) period[CNT_W-1:16] <= writedata[CNT_W-17:0];
            if (wr_snap) snap <= cnt;
        end
    end
endmodule

// File: rtl/computer_system_multi_timer.sv
// computer_system_multi_timer: NUM_CH interval timers behind one Avalon-MM slave with registered reads
module computer_system_multi_timer
    import computer_system_multi_timer_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h00BEBC1F,
    parameter bit          RUN_AT_RESET   = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(NUM_CH)+2:0]    address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [15:0]                  writedata,
    output logic [15:0]                  readdata,
    output logic [NUM_CH-1:0]            irq_ch,
    output logic                         irq
);
    localparam int AW = $clog2(NUM_CH) + 3;
    logic [AW-1:0] ch;
    logic [15:0] rdata [NUM_CH];
    logic [15:0] mux;
    logic wr;
    assign ch  = address >> 3;
    assign wr  = chipselect && !write_n;
    assign irq = |irq_ch;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        computer_system_timer_channel #(
            .CNT_W(CNT_W),
            .DEFAULT_PERIOD(DEFAULT_PERIOD),
            .RUN_AT_RESET(RUN_AT_RESET)
        ) u_ch (
            .clk(clk),
            .reset(reset),
            .wr(wr && ch == AW'(i)),
            .reg_sel(address[2:0]),
            .writedata(writedata),
            .rdata(rdata[i]),
            .irq(irq_ch[i])
        );
    end
    always_comb begin
        mux = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (ch == AW'(c)) mux = rdata[c];
    end
    always_ff @(posedge clk)
        readdata <= reset ? '0 : mux;
endmodule

// File: tb/tb_computer_system_multi_timer.sv
// tb_computer_system_multi_timer: table vectors, directed corner sequences and a random run against a reference model
module tb_computer_system_multi_timer;
    logic clk = 0, reset = 1;
    logic [4:0] address = '0;
    logic chipselect = 0, write_n = 1;
    logic [15:0] writedata = '0, readdata;
    logic [3:0] irq_ch;
    logic irq;
    logic [5:0] b_address = '0;
    logic b_cs = 0, b_wn = 1;
    logic [15:0] b_wd = '0, b_rd;
    logic [4:0] b_irq_ch;
    logic b_irq;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    computer_system_multi_timer dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq_ch(irq_ch), .irq(irq)
    );

    computer_system_multi_timer #(.NUM_CH(5), .CNT_W(20), .RUN_AT_RESET(1'b0)) dut_b (
        .clk(clk), .reset(reset), .address(b_address), .chipselect(b_cs),
        .write_n(b_wn), .writedata(b_wd), .readdata(b_rd),
        .irq_ch(b_irq_ch), .irq(b_irq)
    );

    // abstract per-channel state of the 4-channel, 32-bit instance
    logic [31:0] m_cnt [4], m_per [4], m_snap [4];
    logic [3:0] m_run, m_to, m_ito, m_cont, m_rl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 32'h00BEBC1F;
            m_per[c] = 32'h00BEBC1F;
            m_snap[c] = '0;
        end
        m_run = '1; m_to = '0; m_ito = '0; m_cont = '1; m_rl = '0;
    endfunction

    function automatic logic [15:0] m_read(input logic [4:0] a);
        int c = int'(a[4:3]);
        case (a[2:0])
            3'd0: return {14'd0, m_run[c], m_to[c]};
            3'd1: return {14'd0, m_cont[c], m_ito[c]};
            3'd2: return m_per[c][15:0];
            3'd3: return m_per[c][31:16];
            3'd4: return m_snap[c][15:0];
            3'd5: return m_snap[c][31:16];
            default: return 16'h0;
        endcase
    endfunction

    function automatic void model_step(input logic w, input logic [4:0] a, input logic [15:0] d);
        for (int c = 0; c < 4; c++) begin
            logic hit, tmo, old_cont;
            logic [2:0] r;
            hit = w && a[4:3] == 2'(c);
            r = a[2:0];
            tmo = m_run[c] && m_cnt[c] == 0;
            old_cont = m_cont[c];
            if (hit && (r == 4 || r == 5)) m_snap[c] = m_cnt[c];
            if (m_rl[c] || tmo) m_cnt[c] = m_per[c];
            else if (m_run[c]) m_cnt[c] = m_cnt[c] - 1;
            m_rl[c] = hit && (r == 2 || r == 3);
            if (tmo) m_to[c] = 1'b1;
            else if (hit && r == 0) m_to[c] = 1'b0;
            if (hit && r == 1 && d[2]) m_run[c] = 1'b1;
            if (tmo && !old_cont) m_run[c] = 1'b0;
            if (hit && r == 1 && d[3]) m_run[c] = 1'b0;
            if (hit && r == 1) begin
                m_ito[c] = d[0];
                m_cont[c] = d[1];
            end
            if (hit && r == 2) m_per[c][15:0] = d;
            if (hit && r == 3) m_per[c][31:16] = d;
        end
    endfunction

    task automatic cyc(input logic w, input logic [4:0] a, input logic [15:0] d);
        logic [15:0] e;
        int k = $urandom_range(0, 2);
        address = a;
        writedata = d;
        chipselect = w ? 1'b1 : (k == 0);
        write_n = w ? 1'b0 : (k != 1);
        e = m_read(a);
        @(posedge clk);
        model_step(w, a, d);
        #1;
        chk("readdata", 32'(readdata), 32'(e));
        chk("irq_ch", 32'(irq_ch), 32'(m_to & m_ito));
        chk("irq", 32'(irq), 32'(|(m_to & m_ito)));
        chipselect = 0;
        write_n = 1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'($urandom), 16'h0);
    endtask

    task automatic rd(input logic [4:0] a, input logic [15:0] exp, input string nm);
        cyc(1'b0, a, 16'h0);
        chk(nm, 32'(readdata), 32'(exp));
    endtask

    task automatic rst_cyc();
        reset = 1;
        chipselect = 0;
        write_n = 1;
        @(posedge clk);
        model_reset();
        #1;
        chk("reset_readdata", 32'(readdata), 32'h0);
        chk("reset_irq", 32'({irq, irq_ch}), 32'h0);
        reset = 0;
    endtask

    task automatic b_cyc(input logic w, input logic [5:0] a, input logic [15:0] d);
        b_address = a;
        b_cs = w;
        b_wn = ~w;
        b_wd = d;
        @(posedge clk);
        #1;
        b_cs = 0;
        b_wn = 1;
    endtask

    typedef struct packed {
        logic        w;
        logic [5:0]  wa;
        logic [15:0] wd;
        logic [5:0]  ra;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [20];

    initial begin
        int n;
        logic [4:0] a;
        logic [15:0] d;
        tbl = '{
            '{1'b0, 6'd0,  16'h0000, 6'd0,  16'h0000},
            '{1'b0, 6'd0,  16'h0000, 6'd1,  16'h0002},
            '{1'b0, 6'd0,  16'h0000, 6'd2,  16'hBC1F},
            '{1'b0, 6'd0,  16'h0000, 6'd3,  16'h000E},
            '{1'b1, 6'd3,  16'hFFFF, 6'd3,  16'h000F},
            '{1'b1, 6'd2,  16'h1234, 6'd2,  16'h1234},
            '{1'b1, 6'd42, 16'hAAAA, 6'd42, 16'h0000},
            '{1'b1, 6'd40, 16'hFFFF, 6'd40, 16'h0000},
            '{1'b0, 6'd0,  16'h0000, 6'd10, 16'hBC1F},
            '{1'b0, 6'd0,  16'h0000, 6'd2,  16'h1234},
            '{1'b1, 6'd4,  16'h5555, 6'd5,  16'h000F},
            '{1'b0, 6'd0,  16'h0000, 6'd4,  16'h1234},
            '{1'b1, 6'd7,  16'hFFFF, 6'd7,  16'h0000},
            '{1'b1, 6'd6,  16'hFFFF, 6'd6,  16'h0000},
            '{1'b1, 6'd33, 16'hFFFF, 6'd33, 16'h0003},
            '{1'b0, 6'd0,  16'h0000, 6'd32, 16'h0000},
            '{1'b1, 6'd9,  16'h0004, 6'd8,  16'h0002},
            '{1'b0, 6'd0,  16'h0000, 6'd29, 16'h0000},
            '{1'b1, 6'd5,  16'h0000, 6'd61, 16'h0000},
            '{1'b1, 6'd58, 16'h0007, 6'd57, 16'h0000}
        };
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_a", 32'(readdata), 32'h0);
        chk("rst_rd_b", 32'(b_rd), 32'h0);
        chk("rst_irq_a", 32'({irq, irq_ch}), 32'h0);
        reset = 0;

        foreach (tbl[i]) begin
            if (tbl[i].w) b_cyc(1'b1, tbl[i].wa, tbl[i].wd);
            b_cyc(1'b0, tbl[i].ra, 16'h0);
            chk($sformatf("tbl%0d", i), 32'(b_rd), 32'(tbl[i].exp));
        end
        chk("b_irq", 32'({b_irq, b_irq_ch}), 32'h0);

        rst_cyc();
        for (int c = 0; c < 4; c++) rd(5'(c * 8), 16'h0002, "status_reset");

        cyc(1'b1, 5'd18, 16'd5);
        cyc(1'b1, 5'd19, 16'd0);
        cyc(1'b1, 5'd17, 16'h0007);
        n = 0;
        while (!irq_ch[2] && n < 60) begin idle(); n++; end
        chk("ch2_first_to", 32'(irq_ch[2]), 32'h1);
        chk("ch2_irq", 32'(irq), 32'h1);
        cyc(1'b1, 5'd16, 16'h0);
        chk("ch2_clear", 32'({irq, irq_ch[2]}), 32'h0);
        n = 0;
        while (!irq_ch[2] && n < 20) begin idle(); n++; end
        chk("ch2_interval", 32'(n), 32'd5);
        repeat (5) idle();
        cyc(1'b1, 5'd16, 16'h0);
        rd(5'd16, 16'h0003, "to_set_wins");

        cyc(1'b1, 5'd10, 16'd3);
        cyc(1'b1, 5'd11, 16'd0);
        cyc(1'b1, 5'd9, 16'h0005);
        repeat (12) idle();
        rd(5'd8, 16'h0001, "oneshot_status");
        chk("oneshot_irq", 32'(irq_ch[1]), 32'h1);
        cyc(1'b1, 5'd12, 16'h0);
        rd(5'd12, 16'd3, "oneshot_hold");
        rd(5'd13, 16'd0, "oneshot_snap_h");

        cyc(1'b1, 5'd2, 16'd1000);
        cyc(1'b1, 5'd3, 16'd0);
        repeat (9) idle();
        cyc(1'b1, 5'd4, 16'h0);
        rd(5'd4, 16'd992, "snap_l");
        rd(5'd5, 16'd0, "snap_h");

        cyc(1'b1, 5'd25, 16'h000C);
        rd(5'd24, 16'h0000, "start_stop");

        rst_cyc();
        rd(5'd16, 16'h0002, "status_after_reset");

        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, 5'(c * 8 + 2), 16'($urandom_range(0, 9)));
            cyc(1'b1, 5'(c * 8 + 3), 16'h0);
            cyc(1'b1, 5'(c * 8 + 1), 16'($urandom_range(0, 3)) | 16'h4);
        end
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) rst_cyc();
            else begin
                a = 5'($urandom);
                d = a[2:0] == 3'd1 ? 16'($urandom_range(0, 15)) :
                    a[2:0] == 3'd2 ? 16'($urandom_range(0, 9)) :
                    a[2:0] == 3'd3 ? ($urandom_range(0, 9) == 0 ? 16'd1 : 16'd0) :
                    16'($urandom);
                cyc($urandom_range(0, 3) == 0, a, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
